// File: rtl/link_round_robin_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : link_round_robin_arbiter_if
// Purpose  : Bundles the requester-side and link-side valid/ready signals of
//            the round-robin link arbiter.
// Ports    : in_data/in_valid/in_last/in_ready - NUM_REQ requester channels
//            out_data/out_valid/out_last/out_src/out_ready - link channel
//            busy - arbiter holds a packet lock or an undelivered beat
// Modports : slave  - arbiter view
//            master - environment view (requesters + link)
// Revision : 1.0 - initial release
// ============================================================================
interface link_round_robin_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ-1:0]            in_last;
  logic [NUM_REQ-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_last;
  logic [ID_WIDTH-1:0]           out_src;
  logic                          out_ready;
  logic                          busy;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_src, busy
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_src, busy
  );
endinterface
`default_nettype wire

// File: rtl/link_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : link_round_robin_arbiter
// Purpose  : Shares one valid/ready link among NUM_REQ requesters with
//            packet-atomic round-robin arbitration and a registered output
//            stage (one beat per cycle, one cycle latency).
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous assert, active-high
//            bus   - link_round_robin_arbiter_if.slave (requester inputs,
//                    combinational in_ready, registered out_* and busy)
// Revision : 1.0 - initial release
// ============================================================================
module link_round_robin_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  link_round_robin_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [ID_WIDTH-1:0]   lock_id_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [ID_WIDTH-1:0]   out_src_q;

  logic                  load_en;
  logic                  any_elig;
  logic                  xfer;
  logic [ID_WIDTH-1:0]   grant_sel;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_last;

  // Requester index at a given offset from base, wrapping at NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] idx);
    if (idx == ID_WIDTH'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Output register can take a beat when empty or being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    grant_sel = '0;
    any_elig  = 1'b0;
    if (state_q == ST_LOCKED) begin
      // Locked: only the packet owner may send; absent valid means a bubble.
      grant_sel = lock_id_q;
      any_elig  = bus.in_valid[lock_id_q];
    end else begin
      // Scan from the farthest offset back to ptr so the nearest valid
      // requester (in wrap order) is the one left in grant_sel.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (bus.in_valid[rr_index(ptr_q, k)]) begin
          grant_sel = rr_index(ptr_q, k);
          any_elig  = 1'b1;
        end
      end
    end
  end

  assign xfer       = load_en && any_elig;
  assign grant_data = bus.in_data[int'(grant_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_last = bus.in_last[grant_sel];

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lock_id_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      if (xfer) begin
        out_data_q  <= grant_data;
        out_last_q  <= grant_last;
        out_src_q   <= grant_sel;
        out_valid_q <= 1'b1;
        if (state_q == ST_IDLE) begin
          // Single-beat packets release the link immediately.
          if (grant_last) begin
            ptr_q <= wrap_inc(grant_sel);
          end else begin
            state_q   <= ST_LOCKED;
            lock_id_q <= grant_sel;
          end
        end else if (grant_last) begin
          state_q <= ST_IDLE;
          ptr_q   <= wrap_inc(lock_id_q);
        end
      end else if (load_en) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state_q == ST_LOCKED) || out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_link_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_round_robin_arbiter
// Purpose  : Self-checking bench for link_round_robin_arbiter: requester
//            packet generators, an integer round-robin reference model feeding
//            an expected-beat queue, and an output monitor that compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_round_robin_arbiter;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  link_round_robin_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  link_round_robin_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] src;
  } beat_t;

  beat_t         exp_q[$];
  int            src_log[$];
  logic [DW-1:0] data_log[$];
  int total = 0;
  int bad   = 0;

  // Requester packet state: beats remaining (incl. current), valid, beat data.
  int            rem[N];
  bit            vld[N];
  logic [DW-1:0] dat[N];

  // Reference arbiter: owner = requester holding the link (-1 none).
  int owner = -1;
  int ptr   = 0;
  bit m_ov  = 1'b0;

  int p_start  = 0;
  int p_resume = 100;
  int p_cont   = 100;
  int max_len  = 1;
  int p_ready  = 100;

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick();
    if (owner >= 0) return vld[owner] ? owner : -1;
    for (int k = 0; k < N; k++) begin
      if (vld[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i]           = vld[i];
      bus.in_last[i]            = (rem[i] == 1);
      bus.in_data[i*DW +: DW]   = dat[i];
    end
  endtask

  task automatic load(input int i, input int len, input logic [DW-1:0] d);
    rem[i] = len;
    vld[i] = 1'b1;
    dat[i] = d;
  endtask

  task automatic cycle();
    bit            le;
    int            w;
    logic [N-1:0]  er;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0) begin
        if (rnd(p_start)) load(i, $urandom_range(1, max_len), {$urandom, $urandom});
      end else if (!vld[i] && rnd(p_resume)) begin
        vld[i] = 1'b1;
      end
    end
    drive_inputs();
    bus.out_ready = rnd(p_ready);
    #1;
    le = !m_ov || bus.out_ready;
    w  = pick();
    er = '0;
    if (le && w >= 0) er[w] = 1'b1;
    chk("in_ready",  64'(bus.in_ready),  64'(er));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("busy",      64'(bus.busy),      64'((owner >= 0) || m_ov));
    if (le && w >= 0) begin
      exp_q.push_back('{data: dat[w], last: (rem[w] == 1), src: IW'(w)});
      if (rem[w] == 1) begin
        owner = -1;
        ptr   = (w + 1) % N;
      end else begin
        owner = w;
      end
      rem[w]--;
      if (rem[w] > 0) begin
        dat[w] = {$urandom, $urandom};
        vld[w] = rnd(p_cont);
      end else begin
        vld[w] = 1'b0;
      end
      m_ov = 1'b1;
    end else if (le) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic check_outputs_clear(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_out_data"},  bus.out_data,       64'(0));
    chk({tag, "_out_last"},  64'(bus.out_last),  64'(0));
    chk({tag, "_out_src"},   64'(bus.out_src),   64'(0));
    chk({tag, "_busy"},      64'(bus.busy),      64'(0));
  endtask

  // Asserts reset mid-cycle, checks the immediate clear, then releases it
  // mid-cycle after two edges.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_clear("rst");
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    drive_inputs();
    owner = -1;
    ptr   = 0;
    m_ov  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input int exp_src);
    if (idx >= src_log.size()) begin
      total++;
      bad++;
      $display("FAIL %s: beat %0d missing, got %0d beats expected more", name, idx, src_log.size());
    end else begin
      chk(name, 64'(src_log[idx]), 64'(exp_src));
    end
  endtask

  // Monitor: compares each presented beat with the queue head and retires it
  // on the handshake.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got src %0d data %0h expected none", bus.out_src, bus.out_data);
        end else begin
          e = exp_q[0];
          chk("out_data", bus.out_data,       e.data);
          chk("out_last", 64'(bus.out_last),  64'(e.last));
          chk("out_src",  64'(bus.out_src),   64'(e.src));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            src_log.push_back(int'(bus.out_src));
            data_log.push_back(bus.out_data);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    drive_inputs();
    bus.out_ready = 1'b1;

    // Reset state, during and just after release at 107ns.
    #100;
    check_outputs_clear("por");
    chk("por_in_ready", 64'(bus.in_ready), 64'(0));
    #7;
    reset = 1'b0;
    #1;
    check_outputs_clear("rel");
    chk("rel_in_ready", 64'(bus.in_ready), 64'(0));

    // Fairness: continuous single-beat packets from everyone.
    p_start = 100; max_len = 1; p_ready = 100;
    src_log.delete();
    repeat (9) cycle();
    for (int k = 0; k < 6; k++) check_log("fair_src", k, k % N);
    p_start = 0;
    repeat (5) cycle();

    // Packet lock: req1 4 beats while req0 and req2 wait.
    do_reset();
    load(0, 1, 64'h100);
    repeat (3) cycle();
    src_log.delete();
    load(1, 4, 64'h1000);
    load(0, 1, 64'h2000);
    load(2, 1, 64'h3000);
    repeat (9) cycle();
    check_log("lock_src", 0, 1);
    check_log("lock_src", 1, 1);
    check_log("lock_src", 2, 1);
    check_log("lock_src", 3, 1);
    check_log("lock_src", 4, 2);
    check_log("lock_src", 5, 0);

    // Backpressure: five stalled cycles with a beat held on the output.
    load(0, 3, 64'hAAAA);
    load(1, 2, 64'hBBBB);
    repeat (2) cycle();
    p_ready = 0;
    repeat (5) cycle();
    p_ready = 100;
    repeat (7) cycle();

    // Lock with bubble: req0 sends 0xA, idles 3 cycles, then 0xB; req1 waits.
    do_reset();
    src_log.delete();
    data_log.delete();
    p_cont = 0; p_resume = 0;
    load(0, 2, 64'hA);
    load(1, 1, 64'h1111);
    cycle();
    dat[0] = 64'hB;
    repeat (3) cycle();
    vld[0] = 1'b1;
    p_resume = 100; p_cont = 100;
    repeat (4) cycle();
    check_log("bubble_src", 0, 0);
    check_log("bubble_src", 1, 0);
    check_log("bubble_src", 2, 1);
    if (data_log.size() >= 2) begin
      chk("bubble_data0", data_log[0], 64'hA);
      chk("bubble_data1", data_log[1], 64'hB);
    end else begin
      total++;
      bad++;
      $display("FAIL bubble_data: got %0d beats expected 2", data_log.size());
    end

    // Mid-packet reset during beat 2 of req2's 4-beat packet.
    do_reset();
    load(2, 4, {$urandom, $urandom});
    repeat (2) cycle();
    do_reset();
    src_log.delete();
    load(0, 1, 64'h10);
    load(1, 1, 64'h11);
    load(2, 1, 64'h12);
    repeat (4) cycle();
    check_log("post_rst_src", 0, 0);

    // Random traffic with random backpressure, then drain.
    p_start = 30; max_len = 4; p_cont = 70; p_resume = 40; p_ready = 70;
    repeat (400) cycle();
    p_start = 0; p_cont = 100; p_resume = 100; p_ready = 100;
    repeat (20) cycle();
    @(negedge clk);
    #3;
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
